// File: rtl/ksa_shuffle.sv
// rtl/ksa_shuffle.sv - RC4 key-scheduling shuffle, requester 2 of the S-memory arbiter
module ksa_shuffle #(
    parameter int KEY_BYTES = 3,
    parameter int KEY_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] secret_key,
    output logic                 done,
    output logic                 request,
    output logic                 wrt,
    output logic [7:0]           address,
    output logic [7:0]           data_out,
    input  logic [7:0]           data_in,
    input  logic                 finished
);
    localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_SI, CALC_J, RD_SJ, WR_SI, WR_SJ, NEXT, DONE
    } state_t;

    state_t         state_q;
    logic [7:0]     i_q, j_q, si_q, sj_q;
    logic [KIW-1:0] kidx_q;
    logic           request_q, wrt_q, done_q;
    logic [7:0]     address_q, data_q;
    logic [7:0]     key_byte;
    logic [7:0]     j_d;

    // Pick key byte (i mod KEY_BYTES); byte 0 lives in the MSBs of secret_key
    always_comb begin
        key_byte = 8'd0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (int'(kidx_q) == k) key_byte = secret_key[KEY_WIDTH-1-8*k -: 8];
        end
    end

    assign j_d = j_q + si_q + key_byte;

    // Shuffle FSM: every *_REQ state spends its first cycle with request low
    // (the inter-transaction gap), then holds the request until finished.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            si_q      <= 8'd0;
            sj_q      <= 8'd0;
            kidx_q    <= '0;
            request_q <= 1'b0;
            wrt_q     <= 1'b0;
            address_q <= 8'd0;
            data_q    <= 8'd0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        i_q     <= 8'd0;
                        j_q     <= 8'd0;
                        kidx_q  <= '0;
                        done_q  <= 1'b0;
                        state_q <= RD_SI;
                    end
                end
                RD_SI: begin
                    if (!request_q) begin
                        request_q <= 1'b1;
                        wrt_q     <= 1'b0;
                        address_q <= i_q;
                    end else if (finished) begin
                        request_q <= 1'b0;
                        si_q      <= data_in;
                        state_q   <= CALC_J;
                    end
                end
                CALC_J: begin
                    j_q     <= j_d;
                    state_q <= RD_SJ;
                end
                RD_SJ: begin
                    if (!request_q) begin
                        request_q <= 1'b1;
                        wrt_q     <= 1'b0;
                        address_q <= j_q;
                    end else if (finished) begin
                        request_q <= 1'b0;
                        sj_q      <= data_in;
                        state_q   <= WR_SI;
                    end
                end
                WR_SI: begin
                    if (!request_q) begin
                        request_q <= 1'b1;
                        wrt_q     <= 1'b1;
                        address_q <= i_q;
                        data_q    <= sj_q;
                    end else if (finished) begin
                        request_q <= 1'b0;
                        state_q   <= WR_SJ;
                    end
                end
                WR_SJ: begin
                    if (!request_q) begin
                        request_q <= 1'b1;
                        wrt_q     <= 1'b1;
                        address_q <= j_q;
                        data_q    <= si_q;
                    end else if (finished) begin
                        request_q <= 1'b0;
                        state_q   <= NEXT;
                    end
                end
                NEXT: begin
                    if (i_q == 8'hFF) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        i_q     <= i_q + 8'd1;
                        kidx_q  <= (kidx_q == KIW'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
                        state_q <= RD_SI;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done     = done_q;
    assign request  = request_q;
    assign wrt      = wrt_q;
    assign address  = address_q;
    assign data_out = data_q;

endmodule

// File: doc/ksa_shuffle.md
Name: ksa_shuffle

Overview:
- Key-scheduling shuffle stage of the RC4 datapath.
- Runs after S-memory initialisation (S[k]=k, via requester port 1) and before decryption (requester port 3).
- Acts as requester 2 of the S-memory arbiter, using the arbiter's request/wrt/address/data/finished handshake.
- For i = 0..255: j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].

Parameters:
- KEY_BYTES, 3: secret key length in bytes.
- KEY_WIDTH, 24: secret_key width; must equal 8*KEY_BYTES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin shuffle; sampled in IDLE or DONE only.
- secret_key  in  KEY_WIDTH  key; byte 0 = secret_key[KEY_WIDTH-1 -: 8] (MSB first); must be stable while busy.
- done  out  1  high from shuffle completion until the next start or reset.
- request  out  1  memory request to arbiter (request_2).
- wrt  out  1  1=write, 0=read (wrt_2); valid while request=1.
- address  out  8  S address (address_2); valid while request=1.
- data_out  out  8  write data (data_2); valid while request=1 and wrt=1.
- data_in  in  8  read data from arbiter (data_2_out); valid in the cycle finished=1.
- finished  in  1  one-cycle completion pulse from arbiter (finished_2).

Behaviour:
- Reset: state=IDLE; request=0, wrt=0, address=0, data_out=0, done=0, i=0, j=0, si=0, sj=0.
- Handshake:
  - In each *_REQ state, request=1 with wrt/address/data_out held constant until finished is sampled high.
  - On that edge: reads capture data_in; FSM advances to a non-requesting state, so request=0 for at least 1 cycle between transactions.
  - finished sampled outside a *_REQ state is ignored.
- States:
  - IDLE: start=1 -> i=0, j=0, done=0 -> RD_SI.
  - RD_SI: read address=i; on finished, si<=data_in -> CALC_J.
  - CALC_J: j <= j + si + keybyte(i mod KEY_BYTES), modulo 256 (8-bit wrap, carries discarded) -> RD_SJ.
  - RD_SJ: read address=j; on finished, sj<=data_in -> WR_SI.
  - WR_SI: write address=i, data_out=sj; on finished -> WR_SJ.
  - WR_SJ: write address=j, data_out=si; on finished -> NEXT.
  - NEXT: if i==255 -> DONE, else i<=i+1 -> RD_SI.
  - DONE: done=1; start=1 -> restart as from IDLE (done drops next cycle).
- Per iteration: exactly 2 reads and 2 writes, in the order S[i] read, S[j] read, S[i] write, S[j] write.
- Per run: 256 iterations, 1024 transactions.
- i==j: all 4 accesses still performed. Second write stores the original si to the same address, so S is unchanged.
- i never wraps; termination is decided at i==255 in NEXT.
- key index: i mod KEY_BYTES, computed by a counter that wraps at KEY_BYTES-1. No divider.
- start while busy (not IDLE/DONE) is ignored.
- Reset mid-operation:
  - Next cycle: request=0 and state=IDLE.
  - An arbiter transaction already in flight completes on its own; its finished pulse is ignored in IDLE.
  - A new start begins again at i=0, j=0.
- Throughput: with minimum arbiter latency, an iteration costs 4 transactions + CALC_J + NEXT + 4 gap cycles.

Test Plan:
- Reset: assert reset 3 cycles mid-idle -> all outputs 0; request stays 0 with start=0 for 50 cycles.
- Identity S (S[k]=k), key 0x000000: i=0 gives j=0 (same-address swap), i=1 gives j=1, i=2 gives j=3 (swap 2,3) -> final S matches software RC4 KSA model bytewise; done=1; exactly 1024 finished pulses consumed.
- Identity S, key 0x4A2B1C: first iteration -> reads addr 0x00 then 0x4A, then write 0x00<=0x4A, then write 0x4A<=0x00. Second iteration -> j=0x4A+0x01+0x2B=0x76. Final S matches model.
- Handshake stress: arbiter model delays finished 1..9 cycles randomly -> address/wrt/data_out never change while request=1; request low ≥1 cycle after each finished; spurious finished in IDLE ignored.
- Reset at i=0x80 during RD_SJ -> request=0 next cycle, done=0. Re-init S, start -> final S identical to an uninterrupted run.
- start pulsed at i=0x10 -> ignored, run result unchanged. start held high in DONE -> new run begins, done drops next cycle.
